// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   WIDTH_DEF : default operand/result width
//   state_e   : controller states
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/FA.sv
// 1-bit full adder.
//   a, b : addend bits
//   c    : carry in
//   sum  : sum bit
//   ca   : carry out
module FA (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic ca
);

  assign sum = a ^ b ^ c;
  assign ca  = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder, one bit per cycle, LSB first.
//   clk, rst   : clock, async active-high reset
//   start      : request, sampled only in IDLE
//   op_a, op_b : operands, captured on the accepting edge
//   cin        : carry in, captured on the accepting edge
//   busy       : high in SHIFT
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : registered result, held until the next DONE or reset
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one result bit per cycle, WIDTH cycles
// DONE  | result published, done pulse, back to IDLE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum;
  logic fa_ca;

  FA u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .c   (carry_q),
    .sum (fa_sum),
    .ca  (fa_ca)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_ca;
        // Stop on the last bit so the counter never goes past WIDTH.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = cnt_q;
          // Publish directly from the FA outputs so the final bit and
          // carry land in sum/cout on the same edge that enters DONE.
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_ca;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
